// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing AHB signals: master request/lock lines, the muxed address-phase
// controls and slave response, and the grant/ownership outputs.
interface ahb_arbiter_if #(
  parameter int N  = 2,
  localparam int MW = $clog2(N)
);
  logic [N-1:0]  HBUSREQ;
  logic [N-1:0]  HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [1:0]    HRESP;
  logic [N-1:0]  HGRANT;
  logic [MW-1:0] HMASTER;
  logic          HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: regrants only at burst boundaries, honours HLOCK,
// and pipelines ownership into HMASTER/HMASTLOCK on HREADY edges.
module ahb_arbiter #(
  parameter int NO_OF_MASTERS  = 2,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = $clog2(NO_OF_MASTERS)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahb_arbiter_if.slave  bus
);
  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1;
  localparam logic [1:0] R_ERROR = 2'd1;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  typedef enum logic [1:0] {ARB, BURST, INCR_B} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               beat_cnt, cnt_nxt, len_m1, len_nxt;
  logic [MW-1:0]            rr_ptr, grant_idx, winner, cand, hmaster;
  logic [MW:0]              sum;
  logic [NO_OF_MASTERS-1:0] hgrant;
  logic                     hmastlock, accepted, lock_held, handover, arb_open, found;

  assign accepted  = bus.HREADY && (bus.HTRANS == T_NONSEQ || bus.HTRANS == T_SEQ);
  assign lock_held = bus.HLOCK[grant_idx] && bus.HBUSREQ[grant_idx];
  // A grant not yet taken up by the ownership pipeline must not be revoked,
  // otherwise the new master's first NONSEQ would be credited to someone else.
  assign handover  = (grant_idx != hmaster);
  assign arb_open  = bus.HREADY && !lock_held && !handover && (state_nxt == ARB);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    len_nxt   = len_m1;
    unique case (state)
      ARB: if (accepted && bus.HTRANS == T_NONSEQ) begin
        if (bus.HBURST == B_INCR) state_nxt = INCR_B;
        else if (bus.HBURST != B_SINGLE) begin
          state_nxt = BURST;
          cnt_nxt   = 4'd1;
          // HBURST[2:1] encodes 4/8/16 beats as 1/2/3
          unique case (bus.HBURST[2:1])
            2'd1:    len_nxt = 4'd3;
            2'd2:    len_nxt = 4'd7;
            default: len_nxt = 4'd15;
          endcase
        end
      end
      BURST: if (accepted) begin
        if (beat_cnt == len_m1) begin
          state_nxt = ARB;
          cnt_nxt   = 4'd0;
        end else cnt_nxt = beat_cnt + 4'd1;
      end
      INCR_B: if (bus.HREADY && (!bus.HBUSREQ[grant_idx] || bus.HTRANS == T_IDLE))
        state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
    if (bus.HRESP == R_ERROR && !bus.HREADY) begin
      state_nxt = ARB;
      cnt_nxt   = 4'd0;
    end
  end

  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 1; i <= NO_OF_MASTERS; i++) begin
      sum = {1'b0, rr_ptr} + (MW+1)'(i);
      if (sum >= (MW+1)'(NO_OF_MASTERS)) sum = sum - (MW+1)'(NO_OF_MASTERS);
      cand = sum[MW-1:0];
      if (!found && bus.HBUSREQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ARB;
      beat_cnt  <= '0;
      len_m1    <= '0;
      rr_ptr    <= DEF_IDX;
      grant_idx <= DEF_IDX;
      hgrant    <= NO_OF_MASTERS'(1) << DEF_IDX;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      len_m1   <= len_nxt;
      if (bus.HREADY) begin
        hmaster   <= grant_idx;
        hmastlock <= bus.HLOCK[grant_idx];
      end
      if (arb_open) begin
        grant_idx <= winner;
        rr_ptr    <= winner;
        hgrant    <= NO_OF_MASTERS'(1) << winner;
      end
    end
  end

  assign bus.HGRANT    = hgrant;
  assign bus.HMASTER   = hmaster;
  assign bus.HMASTLOCK = hmastlock;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Cycle-stepped bench for ahb_arbiter: each step pushes hand-derived expected
// grant/owner/lock values, which are popped and compared after the clock edge.
module tb_ahb_arbiter;
  localparam logic [1:0] IDLE = 2'd0, NS = 2'd2, SQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, WRAP8 = 3'd4, INCR16 = 3'd7;
  localparam logic [1:0] OK = 2'd0, ERR = 2'd1;

  typedef struct {
    logic [1:0] g;
    logic       m;
    logic       l;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];

  ahb_arbiter_if #(.N(2)) bus ();

  ahb_arbiter #(.NO_OF_MASTERS(2), .DEFAULT_MASTER(0)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of bus inputs, then compare outputs just after the edge.
  task automatic step(input string tag, input logic [1:0] req, input logic [1:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic [1:0] rs, input logic [1:0] eg, input logic em,
                      input logic el);
    exp_t e;
    bus.HBUSREQ = req;
    bus.HLOCK   = lk;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    bus.HRESP   = rs;
    e.g = eg; e.m = em; e.l = el; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".grant"}, 32'(bus.HGRANT), 32'(e.g));
    chk({e.tag, ".master"}, 32'(bus.HMASTER), 32'(e.m));
    chk({e.tag, ".lock"}, 32'(bus.HMASTLOCK), 32'(e.l));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HTRANS = IDLE;
    bus.HBURST = SINGLE; bus.HREADY = 1'b1; bus.HRESP = OK;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant", 32'(bus.HGRANT), 32'h1);
    chk("rst.master", 32'(bus.HMASTER), 32'h0);
    chk("rst.lock", 32'(bus.HMASTLOCK), 32'h0);
    rst = 1'b0;

    // M0 INCR4 with both requesting: handover after beat 4, owner one edge later
    step("incr4.b1", 2'b11, 2'b00, NS, INCR4, 1, OK, 2'b01, 0, 0);
    for (int i = 0; i < 2; i++) step("incr4.seq", 2'b11, 2'b00, SQ, INCR4, 1, OK, 2'b01, 0, 0);
    step("incr4.b4", 2'b11, 2'b00, SQ, INCR4, 1, OK, 2'b10, 0, 0);
    step("incr4.bub", 2'b11, 2'b00, IDLE, SINGLE, 1, OK, 2'b10, 1, 0);

    // M1 WRAP8 with wait states mid-burst and before the last beat
    step("wrap8.b1", 2'b11, 2'b00, NS, WRAP8, 1, OK, 2'b10, 1, 0);
    for (int i = 0; i < 3; i++) step("wrap8.seq", 2'b11, 2'b00, SQ, WRAP8, 1, OK, 2'b10, 1, 0);
    for (int i = 0; i < 3; i++) step("wrap8.wait", 2'b11, 2'b00, SQ, WRAP8, 0, OK, 2'b10, 1, 0);
    for (int i = 0; i < 3; i++) step("wrap8.seq2", 2'b11, 2'b00, SQ, WRAP8, 1, OK, 2'b10, 1, 0);
    step("wrap8.wait8", 2'b11, 2'b00, SQ, WRAP8, 0, OK, 2'b10, 1, 0);
    step("wrap8.b8", 2'b11, 2'b00, SQ, WRAP8, 1, OK, 2'b01, 1, 0);
    step("wrap8.bub", 2'b11, 2'b00, IDLE, SINGLE, 1, OK, 2'b01, 0, 0);

    // Locked M1: two back-to-back INCR4 with M0 requesting, lock dropped on last beat
    step("lock.arb", 2'b10, 2'b10, IDLE, SINGLE, 1, OK, 2'b10, 0, 0);
    step("lock.own", 2'b11, 2'b10, IDLE, SINGLE, 1, OK, 2'b10, 1, 1);
    step("lock.a1", 2'b11, 2'b10, NS, INCR4, 1, OK, 2'b10, 1, 1);
    for (int i = 0; i < 3; i++) step("lock.aseq", 2'b11, 2'b10, SQ, INCR4, 1, OK, 2'b10, 1, 1);
    step("lock.b1", 2'b11, 2'b10, NS, INCR4, 1, OK, 2'b10, 1, 1);
    for (int i = 0; i < 2; i++) step("lock.bseq", 2'b11, 2'b10, SQ, INCR4, 1, OK, 2'b10, 1, 1);
    step("lock.b4", 2'b11, 2'b00, SQ, INCR4, 1, OK, 2'b01, 1, 0);
    step("lock.bub", 2'b11, 2'b00, IDLE, SINGLE, 1, OK, 2'b01, 0, 0);

    // M1 INCR until it drops its request, then park on the default master
    step("incr.arb", 2'b10, 2'b00, IDLE, SINGLE, 1, OK, 2'b10, 0, 0);
    step("incr.own", 2'b10, 2'b00, IDLE, SINGLE, 1, OK, 2'b10, 1, 0);
    step("incr.ns", 2'b10, 2'b00, NS, INCR, 1, OK, 2'b10, 1, 0);
    step("incr.seq", 2'b10, 2'b00, SQ, INCR, 1, OK, 2'b10, 1, 0);
    step("incr.drop", 2'b00, 2'b00, SQ, INCR, 1, OK, 2'b01, 1, 0);
    step("park.own", 2'b00, 2'b00, IDLE, SINGLE, 1, OK, 2'b01, 0, 0);
    step("park.idle", 2'b00, 2'b00, IDLE, SINGLE, 1, OK, 2'b01, 0, 0);
    step("sole.single", 2'b01, 2'b00, NS, SINGLE, 1, OK, 2'b01, 0, 0);

    // ERROR response mid-INCR16 cancels the burst and rearbitrates
    step("err.b1", 2'b11, 2'b00, NS, INCR16, 1, OK, 2'b01, 0, 0);
    for (int i = 0; i < 2; i++) step("err.seq", 2'b11, 2'b00, SQ, INCR16, 1, OK, 2'b01, 0, 0);
    step("err.c1", 2'b11, 2'b00, SQ, INCR16, 0, ERR, 2'b01, 0, 0);
    step("err.c2", 2'b11, 2'b00, IDLE, SINGLE, 1, ERR, 2'b10, 0, 0);
    step("err.own", 2'b11, 2'b00, IDLE, SINGLE, 1, OK, 2'b10, 1, 0);

    // Async reset pulse at beat 3 of a locked M1 burst
    step("mrst.b1", 2'b11, 2'b10, NS, INCR4, 1, OK, 2'b10, 1, 1);
    for (int i = 0; i < 2; i++) step("mrst.seq", 2'b11, 2'b10, SQ, INCR4, 1, OK, 2'b10, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst.grant", 32'(bus.HGRANT), 32'h1);
    chk("mrst.master", 32'(bus.HMASTER), 32'h0);
    chk("mrst.lock", 32'(bus.HMASTLOCK), 32'h0);
    #1 rst = 1'b0;
    step("mrst.arb", 2'b11, 2'b00, IDLE, SINGLE, 1, OK, 2'b10, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
